// File: rtl/stream_demux.sv
// Handshaked 1-to-N packet demultiplexer.
// Whole packets are routed to one registered output stage per channel.
module stream_demux #(
  parameter int WIDTH    = 1,
  parameter int SIZE     = 1,
  parameter int CHANNELS = 2 ** SIZE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SIZE-1:0]           in_sel,
  input  logic                      in_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_last,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      busy,
  output logic [SIZE-1:0]           cur_sel,
  output logic                      drop
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e                    state_q;
  logic [SIZE-1:0]           cur_sel_q;
  logic [CHANNELS*WIDTH-1:0] out_data_q;
  logic [CHANNELS-1:0]       out_last_q;
  logic [CHANNELS-1:0]       out_valid_q;
  logic                      drop_q;

  logic [SIZE-1:0]           route;
  logic                      route_ok;
  logic [CHANNELS-1:0]       hit;
  logic                      accept;

  assign route    = (state_q == LOCKED) ? cur_sel_q : in_sel;
  assign route_ok = {1'b0, route} < (SIZE+1)'(CHANNELS);

  // One-hot decode of the current route onto the existing channels
  always_comb begin
    hit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      hit[c] = (route == SIZE'(c));
    end
  end

  // Out-of-range routes act as a sink so the packet is consumed
  assign in_ready = route_ok
                  ? |(hit & (~out_valid_q | out_ready))
                  : 1'b1;
  assign accept   = in_valid && in_ready;

  // Per-channel one-entry output stage; load wins over drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_last_q  <= '0;
      out_valid_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (accept && hit[c]) begin
          out_data_q[c*WIDTH +: WIDTH] <= in_data;
          out_last_q[c]                <= in_last;
          out_valid_q[c]               <= 1'b1;
        end else if (out_valid_q[c] && out_ready[c]) begin
          out_valid_q[c] <= 1'b0;
        end
      end
    end
  end

  // Packet lock: hold the route from first beat until last beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_sel_q <= '0;
    end else if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (!in_last) begin
            state_q   <= LOCKED;
            cur_sel_q <= in_sel;
          end
        end
        LOCKED: begin
          if (in_last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pulse once for every beat swallowed by the sink
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= accept && !route_ok;
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == LOCKED);
  assign cur_sel   = cur_sel_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: a 4-channel and a 3-channel
// instance, directed scenarios plus randomized packets.
module tb_stream_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n;
  logic [1:0][7:0]  in_data;
  logic [1:0][1:0]  in_sel;
  logic [1:0]       in_last;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [1:0][3:0]  ordy;
  logic [1:0][3:0]  ov;
  logic [1:0][3:0]  ol;
  logic [1:0][31:0] od;
  logic [1:0][1:0]  csel;
  logic [1:0]       busy;
  logic [1:0]       drop_w;

  logic        ir4, ir3, bz4, bz3, dr4, dr3;
  logic [1:0]  cs4, cs3;
  logic [31:0] od4;
  logic [23:0] od3;
  logic [3:0]  ol4, ov4;
  logic [2:0]  ol3, ov3;

  stream_demux #(.WIDTH(8), .SIZE(2), .CHANNELS(4)) u4 (
    .clk(clk), .rst_n(rst_n[0]),
    .in_data(in_data[0]), .in_sel(in_sel[0]),
    .in_last(in_last[0]), .in_valid(in_valid[0]),
    .in_ready(ir4),
    .out_data(od4), .out_last(ol4), .out_valid(ov4),
    .out_ready(ordy[0]),
    .busy(bz4), .cur_sel(cs4), .drop(dr4)
  );

  stream_demux #(.WIDTH(8), .SIZE(2), .CHANNELS(3)) u3 (
    .clk(clk), .rst_n(rst_n[1]),
    .in_data(in_data[1]), .in_sel(in_sel[1]),
    .in_last(in_last[1]), .in_valid(in_valid[1]),
    .in_ready(ir3),
    .out_data(od3), .out_last(ol3), .out_valid(ov3),
    .out_ready(ordy[1][2:0]),
    .busy(bz3), .cur_sel(cs3), .drop(dr3)
  );

  assign in_ready = {ir3, ir4};
  assign busy     = {bz3, bz4};
  assign drop_w   = {dr3, dr4};
  assign csel[0]  = cs4;
  assign csel[1]  = cs3;
  assign od[0]    = od4;
  assign od[1]    = {8'h00, od3};
  assign ol[0]    = ol4;
  assign ol[1]    = {1'b0, ol3};
  assign ov[0]    = ov4;
  assign ov[1]    = {1'b0, ov3};

  // Reference model: per-channel expected beat queues + packet route
  logic [8:0] q [8][$];
  bit         mdl_locked [2];
  logic [1:0] mdl_sel [2];
  int         exp_drop [2];
  int         cnt_drop [2];
  bit         rnd_en [2];

  bit         pv [8];
  logic       pl [8];
  logic [7:0] pd [8];

  int n_checks = 0;
  int n_err    = 0;

  function automatic int nch(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic void check(string nm, logic [31:0] act,
                                logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void model_accept(int k, logic [1:0] sel,
                                       logic [7:0] d, logic last);
    logic [1:0] dest;
    dest = mdl_locked[k] ? mdl_sel[k] : sel;
    if (int'(dest) < nch(k)) q[k*4 + int'(dest)].push_back({last, d});
    else exp_drop[k]++;
    mdl_sel[k]    = dest;
    mdl_locked[k] = !last;
  endfunction

  task automatic send(int k, logic [1:0] sel, logic [7:0] d,
                      logic last, output int waits);
    bit acc;
    in_sel[k]   = sel;
    in_data[k]  = d;
    in_last[k]  = last;
    in_valid[k] = 1'b1;
    waits = 0;
    acc = 1'b0;
    for (int n = 0; n < 64 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready[k];
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    if (acc) model_accept(k, sel, d, last);
    else check("accept_timeout", 32'd0, 32'd1);
    in_valid[k] = 1'b0;
  endtask

  task automatic check_clear(int k, string nm);
    check({nm, "_valid"}, 32'(ov[k]), 32'd0);
    check({nm, "_data"}, od[k], 32'd0);
    check({nm, "_last"}, 32'(ol[k]), 32'd0);
    check({nm, "_busy"}, 32'(busy[k]), 32'd0);
    check({nm, "_cursel"}, 32'(csel[k]), 32'd0);
    check({nm, "_drop"}, 32'(drop_w[k]), 32'd0);
  endtask

  task automatic do_reset(int k);
    rst_n[k] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[k] = 1'b1;
    for (int c = 0; c < 4; c++) q[k*4 + c].delete();
    mdl_locked[k] = 1'b0;
    mdl_sel[k]    = 2'd0;
  endtask

  // Randomized consumer backpressure
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rnd_en[k]) ordy[k] = 4'($urandom);
    end
  end

  // Monitor: pop expected beats on each output handshake
  always @(negedge clk) begin
    int i;
    logic [8:0] e;
    for (int k = 0; k < 2; k++) begin
      if (rst_n[k]) begin
        for (int c = 0; c < nch(k); c++) begin
          i = k*4 + c;
          if (pv[i]) begin
            check("stall_hold",
                  {22'd0, ov[k][c], pl[i] ^ ol[k][c],
                   pd[i] ^ od[k][c*8 +: 8]},
                  {22'd0, 1'b1, 1'b0, 8'h00});
          end
          if (ov[k][c] && ordy[k][c]) begin
            if (q[i].size() == 0) begin
              n_checks++;
              n_err++;
              $display("FAIL unexpected_beat: dut %0d ch %0d got %0h expected none",
                       k, c, {ol[k][c], od[k][c*8 +: 8]});
            end else begin
              e = q[i].pop_front();
              check("beat", {23'd0, ol[k][c], od[k][c*8 +: 8]},
                    {23'd0, e});
            end
          end
          pv[i] = ov[k][c] && !ordy[k][c];
          pl[i] = ol[k][c];
          pd[i] = od[k][c*8 +: 8];
        end
        check("busy", 32'(busy[k]), 32'(mdl_locked[k]));
        if (mdl_locked[k]) check("cur_sel", 32'(csel[k]), 32'(mdl_sel[k]));
        if (drop_w[k]) cnt_drop[k]++;
      end else begin
        for (int c = 0; c < 4; c++) pv[k*4 + c] = 1'b0;
      end
    end
  end

  initial begin
    int w;
    int len;
    int d0;
    logic [1:0] s;
    rst_n    = 2'b00;
    in_valid = 2'b00;
    in_last  = 2'b00;
    in_data  = '0;
    in_sel   = '0;
    ordy     = '1;
    for (int k = 0; k < 2; k++) begin
      mdl_locked[k] = 1'b0;
      mdl_sel[k]    = 2'd0;
      exp_drop[k]   = 0;
      cnt_drop[k]   = 0;
      rnd_en[k]     = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_clear(0, "rst4");
    check_clear(1, "rst3");
    rst_n = 2'b11;

    // Single beats to every channel, one-cycle latency
    for (int c = 0; c < 4; c++) begin
      send(0, 2'(c), 8'(8'h10 + c), 1'b1, w);
      check("single_wait", 32'(w), 32'd0);
      check("single_lat",
            {23'd0, ov[0][c], od[0][c*8 +: 8]},
            {23'd0, 1'b1, 8'(8'h10 + c)});
    end

    // 4-beat packet locked to ch2 despite in_sel changing
    send(0, 2'd2, 8'hA0, 1'b0, w);
    send(0, 2'd1, 8'hA1, 1'b0, w);
    check("lock_busy", 32'(busy[0]), 32'd1);
    check("lock_sel", 32'(csel[0]), 32'd2);
    send(0, 2'd1, 8'hA2, 1'b0, w);
    send(0, 2'd1, 8'hA3, 1'b1, w);
    check("unlock_busy", 32'(busy[0]), 32'd0);
    check("lock_last", {23'd0, ol[0][2], od[0][23:16]},
          {23'd0, 1'b1, 8'hA3});

    // Backpressure on ch1, then drain and reload same cycle
    ordy[0] = 4'b1101;
    send(0, 2'd1, 8'h55, 1'b1, w);
    fork
      send(0, 2'd1, 8'h66, 1'b1, w);
      begin
        @(negedge clk);
        check("stall_ready", 32'(in_ready[0]), 32'd0);
        check("stall_data", 32'(od[0][15:8]), 32'h55);
        @(posedge clk);
        #1;
        ordy[0] = 4'hF;
      end
    join
    check("nogap_wait", 32'(w), 32'd1);
    check("nogap", {23'd0, ov[0][1], od[0][15:8]},
          {23'd0, 1'b1, 8'h66});

    // Out-of-range select on the 3-channel instance is sunk
    d0 = cnt_drop[1];
    send(1, 2'd3, 8'hD0, 1'b0, w);
    check("sink_wait0", 32'(w), 32'd0);
    send(1, 2'd0, 8'hD1, 1'b1, w);
    check("sink_wait1", 32'(w), 32'd0);
    @(posedge clk);
    #1;
    check("drop_count", 32'(cnt_drop[1] - d0), 32'd2);
    check("sink_novalid", 32'(ov[1]), 32'd0);
    send(1, 2'd0, 8'hE0, 1'b1, w);
    check("after_sink", {23'd0, ov[1][0], od[1][7:0]},
          {23'd0, 1'b1, 8'hE0});

    // Reset in the middle of a packet
    send(0, 2'd0, 8'hC0, 1'b0, w);
    send(0, 2'd0, 8'hC1, 1'b0, w);
    do_reset(0);
    check_clear(0, "midrst");
    send(0, 2'd1, 8'h77, 1'b1, w);
    check("post_rst", {23'd0, ov[0][1], od[0][15:8]},
          {23'd0, 1'b1, 8'h77});

    // Back-to-back packets, no bubble
    send(0, 2'd0, 8'h31, 1'b1, w);
    check("b2b_wait0", 32'(w), 32'd0);
    send(0, 2'd3, 8'h32, 1'b1, w);
    check("b2b_wait1", 32'(w), 32'd0);
    check("b2b_out", {23'd0, ov[0][3], od[0][31:24]},
          {23'd0, 1'b1, 8'h32});

    // Randomized packets with random backpressure and gaps
    for (int k = 0; k < 2; k++) begin
      rnd_en[k] = 1'b1;
      for (int p = 0; p < 40; p++) begin
        s   = 2'($urandom_range(0, 3));
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(k, (b == 0) ? s : 2'($urandom_range(0, 3)),
               8'($urandom), (b == len - 1), w);
        end
      end
      rnd_en[k] = 1'b0;
      @(posedge clk);
      #1;
      ordy[k] = 4'hF;
    end

    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        check("leftover", 32'(q[k*4 + c].size()), 32'd0);
      end
      check("final_valid", 32'(ov[k]), 32'd0);
      check("final_drops", 32'(cnt_drop[k]), 32'(exp_drop[k]));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
